// File: rtl/matricula_pkg.sv
// rtl/matricula_pkg.sv - shared constants and segment table for the registration-number display
package matricula_pkg;

    localparam int NDIG    = 6;
    localparam int DIGIT_W = 4;
    localparam int IDX_W   = 3;
    localparam int VAL_W   = NDIG * DIGIT_W;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low {g,f,e,d,c,b,a} patterns, element [n] is BCD digit n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

endpackage

// File: rtl/bcd_seg_decoder.sv
// rtl/bcd_seg_decoder.sv - BCD nibble to active-low 7-segment pattern, dash for 10..15
module bcd_seg_decoder
    import matricula_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    output logic [6:0]         seg_n
);

    // Table lookup for 0..9; anything else is not a decimal digit and shows a dash.
    always_comb begin
        seg_n = SEG_DASH;
        if (bcd <= 4'd9) begin
            seg_n = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/matricula_scan_ctrl.sv
// rtl/matricula_scan_ctrl.sv - six-digit multiplexed 7-segment scan controller with frame-aligned shadow
module matricula_scan_ctrl
    import matricula_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [VAL_W-1:0] matricula,
    output logic [NDIG-1:0]  an_n,
    output logic [6:0]       seg_n,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] PS_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    logic [CNT_W-1:0] prescaler;
    logic [IDX_W-1:0] idx;
    logic [VAL_W-1:0] pend_val;
    logic [VAL_W-1:0] shadow;
    logic             pending;

    logic             tick;
    logic             frame_end;
    logic             xfer;
    logic [DIGIT_W-1:0] nibble;
    logic [6:0]       dec_seg;
    logic [NDIG-1:0]  digit_sel;

    assign tick      = en && (prescaler == PS_LAST);
    assign frame_end = tick && (idx == IDX_LAST);
    // Shadow may only change when no frame is mid-scan: at the frame boundary or while dark.
    assign xfer      = frame_end || !en;
    assign digit_sel = NDIG'(1) << idx;

    // Dwell counter; held at zero while disabled so a re-enabled scan gets a full first dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (!en || tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + CNT_W'(1);
        end
    end

    // Digit position, advances once per dwell and wraps after the rightmost digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (!en) begin
            idx <= '0;
        end else if (tick) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end
    end

    // Pending/shadow pair: loads park in pend_val, a load on the transfer edge bypasses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val <= '0;
            pending  <= 1'b0;
            shadow   <= '0;
        end else if (xfer) begin
            if (load) begin
                shadow   <= matricula;
                pend_val <= matricula;
            end else if (pending) begin
                shadow <= pend_val;
            end
            pending <= 1'b0;
        end else if (load) begin
            pend_val <= matricula;
            pending  <= 1'b1;
        end
    end

    // Nibble of the shadow for the current position; position 0 is the leftmost digit.
    always_comb begin
        nibble = '0;
        case (idx)
            3'd0:    nibble = shadow[23:20];
            3'd1:    nibble = shadow[19:16];
            3'd2:    nibble = shadow[15:12];
            3'd3:    nibble = shadow[11:8];
            3'd4:    nibble = shadow[7:4];
            3'd5:    nibble = shadow[3:0];
            default: nibble = '0;
        endcase
    end

    bcd_seg_decoder u_dec (
        .bcd   (nibble),
        .seg_n (dec_seg)
    );

    // Registered pin drivers so the display sees glitch-free anode/segment changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n       <= '1;
            seg_n      <= SEG_BLANK;
            frame_done <= 1'b0;
        end else if (!en) begin
            an_n       <= '1;
            seg_n      <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            an_n       <= ~digit_sel;
            seg_n      <= dec_seg;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_matricula_scan_ctrl.sv
// tb/tb_matricula_scan_ctrl.sv - self-checking bench for matricula_scan_ctrl
module tb_matricula_scan_ctrl;

    localparam int P     = 4;
    localparam int NPOS  = 6;
    localparam int FRAME = NPOS * P;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [23:0] matricula;
    logic [5:0]  an_n;
    logic [6:0]  seg_n;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // Reference state: elapsed enabled cycles plus the value lists the display should hold.
    int          mc;
    logic [23:0] m_shadow;
    logic [23:0] m_pend;
    bit          m_pending;
    logic [5:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_fd;

    matricula_scan_ctrl #(.PRESCALE(P), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .matricula  (matricula),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic model_reset();
        mc        = 0;
        m_shadow  = '0;
        m_pend    = '0;
        m_pending = 0;
        m_an      = 6'h3F;
        m_seg     = 7'h7F;
        m_fd      = 1'b0;
    endtask

    // Advance one clock: update the reference from the inputs seen at this edge, then settle.
    task automatic step();
        int   d;
        logic fb;
        @(posedge clk);
        if (rst_n) begin
            if (en) begin
                d     = (mc / P) % NPOS;
                m_an  = ~(6'b000001 << d);
                m_seg = ref_seg(4'((m_shadow >> (4 * (NPOS - 1 - d))) & 24'hF));
            end else begin
                m_an  = 6'h3F;
                m_seg = 7'h7F;
            end
            fb   = en && ((mc % FRAME) == FRAME - 1);
            m_fd = fb;
            if (!en || fb) begin
                if (load) m_shadow = matricula;
                else if (m_pending) m_shadow = m_pend;
                m_pending = 0;
            end else if (load) begin
                m_pend    = matricula;
                m_pending = 1;
            end
            mc = en ? mc + 1 : 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; load = 1'b0; matricula = '0;
        model_reset();
        #12;
        checks++;
        if (an_n !== 6'h3F) begin errors++; $display("FAIL reset_an_n got=%b exp=%b", an_n, 6'h3F); end
        checks++;
        if (seg_n !== 7'h7F) begin errors++; $display("FAIL reset_seg_n got=%b exp=%b", seg_n, 7'h7F); end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if ({an_n, seg_n, frame_done} !== {m_an, m_seg, m_fd}) begin
            errors++; $display("FAIL reset_idle got=%b/%b/%b exp=%b/%b/%b", an_n, seg_n, frame_done, m_an, m_seg, m_fd);
        end
    endtask

    task automatic test_basic();
        en = 1'b1; load = 1'b1; matricula = 24'h123456;
        for (int s = 1; s <= 48; s++) begin
            step();
            load = 1'b0;
            checks++;
            if ({an_n, seg_n, frame_done} !== {m_an, m_seg, m_fd}) begin
                errors++; $display("FAIL basic_cycle%0d got=%b/%b/%b exp=%b/%b/%b", s, an_n, seg_n, frame_done, m_an, m_seg, m_fd);
            end
            if (s == 24) begin
                checks++;
                if (frame_done !== 1'b1) begin errors++; $display("FAIL basic_first_frame_done got=%b exp=1", frame_done); end
            end
            if (s == 25 || s == 28) begin
                checks++;
                if (an_n !== 6'b111110 || seg_n !== 7'b1111001) begin
                    errors++; $display("FAIL basic_digitA_s%0d got=%b/%b exp=111110/1111001", s, an_n, seg_n);
                end
            end
            if (s == 29) begin
                checks++;
                if (an_n !== 6'b111101 || seg_n !== 7'b0100100) begin
                    errors++; $display("FAIL basic_digitB got=%b/%b exp=111101/0100100", an_n, seg_n);
                end
            end
            if (s == 45) begin
                checks++;
                if (an_n !== 6'b011111 || seg_n !== 7'b0000010) begin
                    errors++; $display("FAIL basic_digitF got=%b/%b exp=011111/0000010", an_n, seg_n);
                end
            end
        end
    endtask

    task automatic test_frame_period();
        int last_fd = -1;
        int npulse  = 0;
        logic prev  = 1'b0;
        for (int s = 0; s < 100; s++) begin
            step();
            checks++;
            if ({an_n, seg_n, frame_done} !== {m_an, m_seg, m_fd}) begin
                errors++; $display("FAIL period_cycle%0d got=%b/%b/%b exp=%b/%b/%b", s, an_n, seg_n, frame_done, m_an, m_seg, m_fd);
            end
            if (frame_done === 1'b1) begin
                npulse++;
                checks++;
                if (prev === 1'b1) begin errors++; $display("FAIL period_width got=2+ cycles exp=1"); end
                if (last_fd >= 0) begin
                    checks++;
                    if (s - last_fd != FRAME) begin errors++; $display("FAIL period_spacing got=%0d exp=%0d", s - last_fd, FRAME); end
                end
                last_fd = s;
            end
            prev = frame_done;
        end
        checks++;
        if (npulse != 4) begin errors++; $display("FAIL period_count got=%0d exp=4", npulse); end
    endtask

    task automatic test_midframe_load();
        int  budget;
        bit  seen;
        budget = 0;
        while (((mc / P) % NPOS) != 2 && budget < 100) begin step(); budget++; end
        load = 1'b1; matricula = 24'h999999;
        seen = 0;
        budget = 0;
        while (!seen && budget < 100) begin
            step();
            load = 1'b0;
            budget++;
            seen = (frame_done === 1'b1);
            checks++;
            if (!seen && seg_n === 7'b0010000) begin
                errors++; $display("FAIL midframe_early got=%b exp=old digit", seg_n);
            end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL midframe_timeout got=no frame_done exp=frame_done"); end
        for (int s = 0; s < FRAME; s++) begin
            step();
            checks++;
            if (seg_n !== 7'b0010000 || an_n !== m_an) begin
                errors++; $display("FAIL midframe_nines got=%b/%b exp=%b/0010000", an_n, seg_n, m_an);
            end
        end
    endtask

    task automatic test_dash();
        int budget;
        bit seen;
        load = 1'b1; matricula = 24'hA0F000;
        step();
        load = 1'b0;
        seen = 0;
        budget = 0;
        while (!seen && budget < 100) begin
            step(); budget++;
            seen = (frame_done === 1'b1);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL dash_timeout got=no frame_done exp=frame_done"); end
        for (int s = 0; s < FRAME; s++) begin
            step();
            checks++;
            if (an_n === 6'b111110 && seg_n !== 7'b0111111) begin errors++; $display("FAIL dash_pos0 got=%b exp=0111111", seg_n); end
            if (an_n === 6'b111101 && seg_n !== 7'b1000000) begin errors++; $display("FAIL dash_pos1 got=%b exp=1000000", seg_n); end
            if (an_n === 6'b111011 && seg_n !== 7'b0111111) begin errors++; $display("FAIL dash_pos2 got=%b exp=0111111", seg_n); end
            if ({an_n, seg_n, frame_done} !== {m_an, m_seg, m_fd}) begin
                errors++; $display("FAIL dash_cycle%0d got=%b/%b/%b exp=%b/%b/%b", s, an_n, seg_n, frame_done, m_an, m_seg, m_fd);
            end
        end
        // Dark period with a parked value, then restart from position 0.
        load = 1'b1; matricula = 24'h246802;
        step();
        load = 1'b0; en = 1'b0;
        for (int s = 0; s < 4; s++) begin
            step();
            checks++;
            if ({an_n, seg_n, frame_done} !== {6'h3F, 7'h7F, 1'b0}) begin
                errors++; $display("FAIL dark_cycle%0d got=%b/%b/%b exp=111111/1111111/0", s, an_n, seg_n, frame_done);
            end
        end
        en = 1'b1;
        step();
        checks++;
        if (an_n !== 6'b111110 || seg_n !== 7'b0100100) begin
            errors++; $display("FAIL enable_first_digit got=%b/%b exp=111110/0100100", an_n, seg_n);
        end
        for (int s = 0; s < 30; s++) begin
            step();
            checks++;
            if ({an_n, seg_n, frame_done} !== {m_an, m_seg, m_fd}) begin
                errors++; $display("FAIL reenable_cycle%0d got=%b/%b/%b exp=%b/%b/%b", s, an_n, seg_n, frame_done, m_an, m_seg, m_fd);
            end
        end
    endtask

    task automatic test_coincident_load();
        int budget;
        budget = 0;
        while ((mc % FRAME) != 3 && budget < 100) begin step(); budget++; end
        load = 1'b1; matricula = 24'h111111;
        step();
        load = 1'b0;
        budget = 0;
        while ((mc % FRAME) != FRAME - 1 && budget < 100) begin step(); budget++; end
        checks++;
        if (budget >= 100) begin errors++; $display("FAIL coincident_timeout got=%0d exp<100", budget); end
        load = 1'b1; matricula = 24'h875310;
        step();
        load = 1'b0;
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL coincident_frame_done got=%b exp=1", frame_done); end
        step();
        checks++;
        if (an_n !== 6'b111110 || seg_n !== 7'b0000000) begin
            errors++; $display("FAIL coincident_first got=%b/%b exp=111110/0000000", an_n, seg_n);
        end
        for (int s = 0; s < 2 * FRAME; s++) begin
            step();
            checks++;
            if ({an_n, seg_n, frame_done} !== {m_an, m_seg, m_fd}) begin
                errors++; $display("FAIL coincident_cycle%0d got=%b/%b/%b exp=%b/%b/%b", s, an_n, seg_n, frame_done, m_an, m_seg, m_fd);
            end
        end
    endtask

    task automatic test_async_reset();
        int budget;
        budget = 0;
        while (((mc / P) % NPOS) != 3 && budget < 100) begin step(); budget++; end
        step();
        step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({an_n, seg_n, frame_done} !== {6'h3F, 7'h7F, 1'b0}) begin
            errors++; $display("FAIL async_reset got=%b/%b/%b exp=111111/1111111/0", an_n, seg_n, frame_done);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (an_n !== 6'b111110 || seg_n !== 7'b1000000) begin
            errors++; $display("FAIL async_restart got=%b/%b exp=111110/1000000", an_n, seg_n);
        end
        for (int s = 0; s < 30; s++) begin
            step();
            checks++;
            if (seg_n !== 7'b1000000 || {an_n, frame_done} !== {m_an, m_fd}) begin
                errors++; $display("FAIL async_zero_cycle%0d got=%b/%b/%b exp=%b/1000000/%b", s, an_n, seg_n, frame_done, m_an, m_fd);
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 600; s++) begin
            en        = ($urandom_range(0, 29) != 0);
            load      = ($urandom_range(0, 9) == 0);
            matricula = 24'($urandom);
            step();
            checks++;
            if ({an_n, seg_n, frame_done} !== {m_an, m_seg, m_fd}) begin
                errors++; $display("FAIL random_cycle%0d got=%b/%b/%b exp=%b/%b/%b", s, an_n, seg_n, frame_done, m_an, m_seg, m_fd);
            end
        end
        en = 1'b1; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_period();
        test_midframe_load();
        test_dash();
        test_coincident_load();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matricula_scan_ctrl.md
Name: matricula_scan_ctrl

Overview:
Time-multiplexing scan controller for the six-digit registration-number display. Takes a 24-bit packed BCD value (six nibbles, digit A = bits 23:20 through digit F = bits 3:0) and drives a common-anode 6-digit 7-segment display one digit at a time. Holds a shadow copy of the value that updates only at frame boundaries, so a displayed number never tears mid-scan. Sits between the number-entry logic and the board display pins.

Parameters:
PRESCALE, 50000, clock cycles each digit stays lit (dwell); legal range >= 1
CNT_W, 16, prescaler counter width; must satisfy 2^CNT_W >= PRESCALE

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; 0 = display dark, scan held
load  in  1  single-cycle strobe; capture matricula
matricula  in  24  packed BCD, A = [23:20] ... F = [3:0]
an_n  out  6  digit anodes, active-low, one-hot-low; an_n[i] = position i, position 0 = leftmost = digit A
seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low
frame_done  out  1  one-cycle pulse at end of each full 6-digit frame

Behaviour:
- Reset (async, rst_n=0): prescaler=0, idx=0, pend_val=0, pending=0, shadow=0, an_n=6'b111111, seg_n=7'b1111111, frame_done=0. All state is cleared immediately, including mid-frame; scanning restarts at idx 0 after release.
- Load: on a clk edge with load=1, pend_val<=matricula and pending<=1. A later load before the frame boundary overwrites pend_val, so the last value wins.
- Tick: prescaler counts 0..PRESCALE-1 while en=1. tick=1 when prescaler==PRESCALE-1; prescaler then wraps to 0. With PRESCALE=1, tick is asserted every cycle.
- idx: 0..5. On tick, idx advances by 1; from 5 it wraps to 0.
- Frame boundary (tick while idx==5):
  - frame_done=1 for exactly that cycle (registered, visible the following cycle-edge).
  - If pending, shadow<=pend_val and pending<=0.
  - If load is also high on that edge, shadow takes the matricula input directly and pending stays 0.
- Outputs: registered, updated every cycle from the current idx and shadow, so there is a 1-cycle lag after an idx or shadow change.
  - an_n = all ones with bit idx cleared.
  - seg_n = decode(shadow nibble for idx); idx 0 selects [23:20], idx 5 selects [3:0].
- Decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibbles 10..15 display a dash: 0111111.
- en=0: prescaler and idx are held at 0; an_n=111111 and seg_n=1111111 on the next edge; frame_done=0. Any pending value transfers to shadow immediately (next edge), so the display restarts with fresh data.
- en 0->1: scan starts at idx 0 with a full PRESCALE dwell. The first lit digit appears 1 cycle after en rises.
- Frame period: 6*PRESCALE cycles; frame_done period is exactly 6*PRESCALE.

Decomposition:
- Shared package (matricula_pkg):
  - NDIG=6 and DIGIT_W=4.
  - Segment constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F.
  - The 10-entry BCD segment table.
- One sub-module: bcd_seg_decoder, combinational, 4-bit in to 7-bit active-low out, dash for >9. It is reused by other display blocks.
- The controller holds the prescaler, idx, load/shadow registers, and output registers.

Test Plan:
- Reset then en=1, PRESCALE=4, load matricula=24'h123456 -> after the first frame boundary, idx0: an_n=111110, seg_n=1111001 ('1'); idx5: an_n=011111, seg_n=0000010 ('6'); each digit lit 4 cycles.
- Steady scan with PRESCALE=4 -> frame_done pulses exactly every 24 cycles, width 1.
- Mid-frame load of 24'h999999 at idx 2 -> digits 2..5 still show the old value; from the next idx 0, all show 0010000.
- Load 24'hA0F000 then scan -> positions 0 and 2 show dash 0111111, position 1 shows 1000000.
- Load coincident with the idx5 tick -> the new value is displayed starting at the immediately following idx 0, and pending stays 0.
- Assert rst_n=0 mid-digit at idx 3 -> outputs go blank asynchronously with no clock needed; after release with en=1, scan resumes at idx 0 with shadow=0 (all digits '0').
